// File: rtl/axis_mux_pkg.sv
// ---------------------------------------------------------------------------
// axis_mux_pkg
// Shared definitions for the AXI-Stream arbitrating multiplexer.
//   arb_state_e : arbiter FSM state (IDLE = waiting to grant, PKT = streaming)
//   MODE_FIXED  : channel chosen by the sel input
//   MODE_RR     : round-robin packet arbitration
//   chan_w()    : width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package axis_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // A channel index needs at least one bit even for degenerate counts.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_arb_mux_if.sv
// ---------------------------------------------------------------------------
// axis_arb_mux_if
// Bundles the N_CH slave streams, the sel input and the single master stream
// of axis_arb_mux.
//   sel      : fixed-mode channel select (SEL_W may be widened so that
//              out-of-range selects can be expressed)
//   s_data   : channel i occupies bits [i*DATA_W +: DATA_W]
//   s_valid, s_last, s_ready : per-channel handshake, one bit per channel
//   m_data, m_valid, m_last, m_ready, m_chan : merged output stream
// Modports:
//   master : the multiplexer (drives s_ready and every m_* except m_ready)
//   slave  : the surrounding logic (drives sources, sel and m_ready)
// ---------------------------------------------------------------------------
interface axis_arb_mux_if
  import axis_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = chan_w(N_CH)
);

  localparam int CH_W = chan_w(N_CH);

  logic [SEL_W-1:0]       sel;
  logic [N_CH*DATA_W-1:0] s_data;
  logic [N_CH-1:0]        s_valid;
  logic [N_CH-1:0]        s_ready;
  logic [N_CH-1:0]        s_last;
  logic [DATA_W-1:0]      m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;
  logic [CH_W-1:0]        m_chan;

  modport master (
    input  sel, s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, m_chan
  );

  modport slave (
    output sel, s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, m_chan
  );

endinterface

// File: rtl/axis_skid_fifo.sv
// ---------------------------------------------------------------------------
// axis_skid_fifo
// Two-entry FIFO used as the registered output stage of the multiplexer.
// The head entry is a register, so out_data comes straight from a flop and
// holds stable while the consumer stalls.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low; empties the FIFO and zeroes the head
//   in_data  : payload to write
//   push     : write request (ignored when full)
//   full     : both entries occupied
//   out_data : head payload (registered)
//   out_valid: FIFO not empty
//   pop      : read request (ignored when empty)
// ---------------------------------------------------------------------------
module axis_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         push,
  output logic         full,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         pop
);

  logic [1:0]   count_reg;
  logic [W-1:0] head_reg;
  logic [W-1:0] tail_reg;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count_reg != 2'd2);
  assign do_pop  = pop  && (count_reg != 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          // New entry lands in the head when empty, behind it otherwise.
          if (count_reg == 2'd0) head_reg <= in_data;
          else                   tail_reg <= in_data;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          // Only advance the head when something is queued behind it;
          // otherwise leave it as-is (out_valid drops anyway).
          if (count_reg == 2'd2) head_reg <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the oldest remaining entry becomes the head.
          if (count_reg == 2'd1) begin
            head_reg <= in_data;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = head_reg;
  assign out_valid = (count_reg != 2'd0);
  assign full      = (count_reg == 2'd2);

endmodule

// File: rtl/axis_arb_mux.sv
// ---------------------------------------------------------------------------
// axis_arb_mux
// Packet-level multiplexer merging N_CH AXI-Stream sources onto one output.
// A grant is issued in IDLE (one arbitration cycle per packet) and held
// until the beat carrying s_last is accepted, so packets never interleave.
// MODE_FIXED takes the channel from sel; MODE_RR searches round-robin from
// the channel after the previous winner. Accepted beats pass through a
// two-entry registered FIFO tagged with their source channel.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : axis_arb_mux_if.master (sel, s_* sources, m_* output, m_chan)
// Parameters:
//   N_CH (2..16), DATA_W, MODE (MODE_FIXED / MODE_RR)
// ---------------------------------------------------------------------------
module axis_arb_mux
  import axis_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = MODE_RR
) (
  input logic            clk,
  input logic            reset,
  axis_arb_mux_if.master bus
);

  localparam int CH_W  = chan_w(N_CH);
  localparam int PAY_W = DATA_W + 1 + CH_W;

  arb_state_e      state_reg;
  logic [CH_W-1:0] grant_reg;
  logic [CH_W-1:0] rr_ptr_reg;

  logic [DATA_W-1:0] ch_data [N_CH];
  logic [DATA_W-1:0] cur_data;
  logic              cur_valid;
  logic              cur_last;
  logic              accept;
  logic [N_CH-1:0]   ready_vec;

  logic              fix_hit;
  logic [CH_W-1:0]   fix_idx;
  logic              rr_hit;
  logic [CH_W-1:0]   rr_idx;
  logic [CH_W-1:0]   rr_cand;

  logic              fifo_full;
  logic              fifo_valid;
  logic [PAY_W-1:0]  fifo_in;
  logic [PAY_W-1:0]  fifo_out;

  // Split the flat data bus into one lane per channel.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      assign ch_data[gi] = bus.s_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Granted channel's view of the source bus.
  assign cur_data  = ch_data[grant_reg];
  assign cur_valid = bus.s_valid[grant_reg];
  assign cur_last  = bus.s_last[grant_reg];

  // Only the granted channel sees ready, and only while streaming with room
  // in the output buffer. The count-based test (not count-minus-pop) keeps
  // s_ready free of any combinational path from m_ready.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (state_reg == PKT && grant_reg == CH_W'(i) && !fifo_full)
        ready_vec[i] = 1'b1;
    end
  end

  assign bus.s_ready = ready_vec;
  assign accept      = (state_reg == PKT) && cur_valid && !fifo_full;

  // Fixed select: a sel value outside 0..N_CH-1 never matches, so the
  // arbiter simply stays idle.
  always_comb begin
    fix_hit = 1'b0;
    fix_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(bus.sel) == i) begin
        fix_hit = bus.s_valid[i];
        fix_idx = CH_W'(i);
      end
    end
  end

  // Round-robin priority search starting at rr_ptr+1. Scanning offsets from
  // the far end downwards lets the nearest valid channel overwrite the rest.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = '0;
    rr_cand = '0;
    for (int off = N_CH; off >= 1; off--) begin
      rr_cand = CH_W'((int'(rr_ptr_reg) + off) % N_CH);
      if (bus.s_valid[rr_cand]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand;
      end
    end
  end

  // Arbiter FSM. rr_ptr resets to the last channel so channel 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= CH_W'(N_CH - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (MODE == MODE_RR) begin
            if (rr_hit) begin
              grant_reg  <= rr_idx;
              rr_ptr_reg <= rr_idx;
              state_reg  <= PKT;
            end
          end else if (fix_hit) begin
            grant_reg <= fix_idx;
            state_reg <= PKT;
          end
        end
        PKT: begin
          if (accept && cur_last) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fifo_in = {cur_data, cur_last, grant_reg};

  axis_skid_fifo #(
    .W (PAY_W)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_data   (fifo_in),
    .push      (accept),
    .full      (fifo_full),
    .out_data  (fifo_out),
    .out_valid (fifo_valid),
    .pop       (fifo_valid && bus.m_ready)
  );

  assign {bus.m_data, bus.m_last, bus.m_chan} = fifo_out;
  assign bus.m_valid = fifo_valid;

endmodule

// File: tb/tb_axis_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_axis_arb_mux
// Directed bench for axis_arb_mux. Two instances share clock and reset:
// u_fix (fixed select, sel widened to 3 bits so sel=5 can be driven) and
// u_rr (round-robin). Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, i.e. they show the state after that edge.
// ---------------------------------------------------------------------------
module tb_axis_arb_mux;
  import axis_mux_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  axis_arb_mux_if #(.N_CH(4), .DATA_W(8), .SEL_W(3)) if_fix ();
  axis_arb_mux_if #(.N_CH(4), .DATA_W(8))            if_rr ();

  axis_arb_mux #(.N_CH(4), .DATA_W(8), .MODE(MODE_FIXED)) u_fix (
    .clk   (clk),
    .reset (reset),
    .bus   (if_fix)
  );

  axis_arb_mux #(.N_CH(4), .DATA_W(8), .MODE(MODE_RR)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (if_rr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_fix.sel = '0; if_fix.s_data = '0; if_fix.s_valid = '0;
    if_fix.s_last = '0; if_fix.m_ready = 1'b0;
    if_rr.sel = '0; if_rr.s_data = '0; if_rr.s_valid = '0;
    if_rr.s_last = '0; if_rr.m_ready = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check("rst_fix_mvalid", if_fix.m_valid, 0);
    check("rst_fix_sready", if_fix.s_ready, 0);
    check("rst_fix_mdata",  if_fix.m_data,  0);
    check("rst_fix_mlast",  if_fix.m_last,  0);
    check("rst_fix_mchan",  if_fix.m_chan,  0);
    check("rst_rr_mvalid",  if_rr.m_valid,  0);
    check("rst_rr_sready",  if_rr.s_ready,  0);
    reset = 1'b1;

    // ---- fixed sel=2, 3-beat packet A1,A2,A3 ----
    if_fix.m_ready = 1'b1; if_fix.sel = 3'd2;
    if_fix.s_data[23:16] = 8'hA1; if_fix.s_last = 4'b0000; if_fix.s_valid = 4'b0100;
    tick();  // arbitration
    check("s1_arb_sready", if_fix.s_ready, 4'b0100);
    check("s1_arb_mvalid", if_fix.m_valid, 0);
    tick();  // A1 accepted
    check("s1_b1_mvalid", if_fix.m_valid, 1);
    check("s1_b1_mdata",  if_fix.m_data,  8'hA1);
    check("s1_b1_mlast",  if_fix.m_last,  0);
    check("s1_b1_mchan",  if_fix.m_chan,  2);
    if_fix.s_data[23:16] = 8'hA2;
    tick();
    check("s1_b2_mdata", if_fix.m_data, 8'hA2);
    check("s1_b2_mlast", if_fix.m_last, 0);
    if_fix.s_data[23:16] = 8'hA3; if_fix.s_last = 4'b0100;
    tick();
    check("s1_b3_mdata",  if_fix.m_data,  8'hA3);
    check("s1_b3_mlast",  if_fix.m_last,  1);
    check("s1_b3_mchan",  if_fix.m_chan,  2);
    check("s1_b3_sready", if_fix.s_ready, 0);
    if_fix.s_valid = 4'b0000; if_fix.s_last = 4'b0000;
    tick();
    check("s1_drain_mvalid", if_fix.m_valid, 0);

    // ---- fixed sel 2->0 after beat 1 of a 4-beat packet ----
    if_fix.sel = 3'd2;
    if_fix.s_data[7:0] = 8'hC1; if_fix.s_data[23:16] = 8'hB1;
    if_fix.s_last = 4'b0001; if_fix.s_valid = 4'b0101;
    tick();
    check("s2_arb_sready", if_fix.s_ready, 4'b0100);
    tick();
    check("s2_b1_mdata", if_fix.m_data, 8'hB1);
    check("s2_b1_mchan", if_fix.m_chan, 2);
    if_fix.sel = 3'd0; if_fix.s_data[23:16] = 8'hB2;
    tick();
    check("s2_b2_mdata",  if_fix.m_data,  8'hB2);
    check("s2_b2_mchan",  if_fix.m_chan,  2);
    check("s2_b2_sready", if_fix.s_ready, 4'b0100);
    if_fix.s_data[23:16] = 8'hB3;
    tick();
    check("s2_b3_mdata", if_fix.m_data, 8'hB3);
    check("s2_b3_mchan", if_fix.m_chan, 2);
    if_fix.s_data[23:16] = 8'hB4; if_fix.s_last = 4'b0101;
    tick();
    check("s2_b4_mdata", if_fix.m_data, 8'hB4);
    check("s2_b4_mlast", if_fix.m_last, 1);
    check("s2_b4_mchan", if_fix.m_chan, 2);
    if_fix.s_valid = 4'b0001;
    tick();
    check("s2_arb0_mvalid", if_fix.m_valid, 0);
    check("s2_arb0_sready", if_fix.s_ready, 4'b0001);
    tick();
    check("s2_c1_mdata", if_fix.m_data, 8'hC1);
    check("s2_c1_mchan", if_fix.m_chan, 0);
    check("s2_c1_mlast", if_fix.m_last, 1);
    if_fix.s_valid = 4'b0000; if_fix.s_last = 4'b0000;
    tick();
    check("s2_drain_mvalid", if_fix.m_valid, 0);

    // ---- fixed sel=5 (out of range) ----
    if_fix.sel = 3'd5; if_fix.s_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s6_sready", if_fix.s_ready, 0);
      check("s6_mvalid", if_fix.m_valid, 0);
    end
    if_fix.s_valid = 4'b0000;

    // ---- backpressure: m_ready low for 5 edges during a packet ----
    if_fix.sel = 3'd1; if_fix.m_ready = 1'b0;
    if_fix.s_data[15:8] = 8'hD1; if_fix.s_valid = 4'b0010;
    tick();
    check("s4_arb_sready", if_fix.s_ready, 4'b0010);
    tick();
    check("s4_b1_mdata",  if_fix.m_data,  8'hD1);
    check("s4_b1_sready", if_fix.s_ready, 4'b0010);
    if_fix.s_data[15:8] = 8'hD2;
    tick();
    check("s4_full_sready", if_fix.s_ready, 0);
    check("s4_full_mdata",  if_fix.m_data,  8'hD1);
    if_fix.s_data[15:8] = 8'hD3; if_fix.s_last = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("s4_hold_mvalid", if_fix.m_valid, 1);
      check("s4_hold_mdata",  if_fix.m_data,  8'hD1);
      check("s4_hold_sready", if_fix.s_ready, 0);
    end
    if_fix.m_ready = 1'b1;
    tick();
    check("s4_rel_mdata",  if_fix.m_data,  8'hD2);
    check("s4_rel_sready", if_fix.s_ready, 4'b0010);
    tick();
    check("s4_d3_mdata", if_fix.m_data, 8'hD3);
    check("s4_d3_mlast", if_fix.m_last, 1);
    if_fix.s_valid = 4'b0000; if_fix.s_last = 4'b0000;
    tick();
    check("s4_drain_mvalid", if_fix.m_valid, 0);

    // ---- round-robin, all channels valid, 1-beat packets ----
    if_rr.m_ready = 1'b1; if_rr.s_data = 32'h13121110;
    if_rr.s_last = 4'b1111; if_rr.s_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s3_gap_mvalid", if_rr.m_valid, 0);
      tick();
      check("s3_beat_mvalid", if_rr.m_valid, 1);
      check("s3_beat_mchan",  if_rr.m_chan,  k % 4);
      check("s3_beat_mdata",  if_rr.m_data,  32'h10 + (k % 4));
    end
    if_rr.s_valid = 4'b0000;
    tick();

    // ---- reset mid-packet with 2 beats buffered ----
    if_rr.m_ready = 1'b0; if_rr.s_last = 4'b0000;
    if_rr.s_data[23:16] = 8'hE1; if_rr.s_valid = 4'b0100;
    tick();  // grant 2
    tick();  // E1 accepted
    if_rr.s_data[23:16] = 8'hE2;
    tick();  // E2 accepted, buffer full
    check("s5_full_mvalid", if_rr.m_valid, 1);
    check("s5_full_sready", if_rr.s_ready, 0);
    check("s5_full_mdata",  if_rr.m_data,  8'hE1);
    reset = 1'b0;
    #1;
    check("s5_rst_mvalid", if_rr.m_valid, 0);
    check("s5_rst_sready", if_rr.s_ready, 0);
    check("s5_rst_mdata",  if_rr.m_data,  0);
    check("s5_rst_mchan",  if_rr.m_chan,  0);
    if_rr.s_data = 32'h13121110; if_rr.s_last = 4'b1111;
    if_rr.s_valid = 4'b1111; if_rr.m_ready = 1'b1;
    #1;
    reset = 1'b1;
    tick();
    check("s5_arb_mvalid", if_rr.m_valid, 0);
    check("s5_arb_sready", if_rr.s_ready, 4'b0001);
    tick();
    check("s5_post_mvalid", if_rr.m_valid, 1);
    check("s5_post_mchan",  if_rr.m_chan,  0);
    check("s5_post_mdata",  if_rr.m_data,  8'h10);
    if_rr.s_valid = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_arb_mux.md
AXIS_ARB_MUX -- requirements
Module: axis_arb_mux

Interface
REQ-001 The block SHALL be parameterised as follows (name, default, meaning):
- N_CH, 4: number of slave channels, 2..16.
- DATA_W, 8: data width in bits.
- MODE, 1: 0 = fixed select via sel; 1 = round-robin packet arbitration.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- sel, in, clog2(N_CH): channel select, used only when MODE=0.
- s_data, in, N_CH*DATA_W: slave data; channel i occupies bits [i*DATA_W +: DATA_W].
- s_valid, in, N_CH: per-channel valid.
- s_ready, out, N_CH: per-channel ready.
- s_last, in, N_CH: per-channel end-of-packet.
- m_data, out, DATA_W: master data.
- m_valid, out, 1: master valid.
- m_ready, in, 1: master ready.
- m_last, out, 1: master end-of-packet.
- m_chan, out, clog2(N_CH): source channel of the current m_data beat.

Function
REQ-003 The block SHALL use a two-state arbiter FSM: IDLE and PKT.
REQ-004 In IDLE with MODE=0, the block SHALL latch grant=sel and enter PKT when s_valid[sel]=1; if sel>=N_CH it SHALL remain in IDLE.
REQ-005 In IDLE with MODE=1, the block SHALL grant the first channel with s_valid=1, searching from rr_ptr+1 with modulo-N_CH wrap, then set rr_ptr=grant and enter PKT.
REQ-006 In IDLE, s_ready SHALL be all-zero and no beat SHALL be accepted; each packet therefore costs exactly one arbitration cycle.
REQ-007 In PKT, s_ready[grant] SHALL be 1 when the output buffer holds fewer than 2 entries, and every other s_ready bit SHALL be 0.
REQ-008 A beat SHALL be accepted on any edge where s_valid[grant]=1 and s_ready[grant]=1.
REQ-009 When an accepted beat has s_last=1, the FSM SHALL return to IDLE on that edge.
REQ-010 Changes to sel or to other channels' s_valid during PKT SHALL be ignored until the packet ends; no packet is ever interleaved.
REQ-011 The output stage SHALL be a 2-entry FIFO carrying {data, last, chan}. m_valid SHALL equal (count!=0), and m_data, m_last and m_chan SHALL be registered outputs read from the head entry.
REQ-012 Latency SHALL be: a beat accepted at edge k into an empty buffer is presented on m_* from edge k onward, i.e. visible in cycle k+1.
REQ-013 While m_valid=1 and m_ready=0, m_data, m_last and m_chan SHALL hold stable.
REQ-014 On an edge with simultaneous push and pop, count SHALL be unchanged and ordering SHALL be preserved. Push while full is impossible by REQ-007.
REQ-015 With m_ready held high and a continuous packet, throughput SHALL be one beat per clock.
REQ-016 A zero-length packet is not possible; a single beat with s_last=1 SHALL form a one-beat packet.

Reset
REQ-017 Assertion of reset (reset=0) SHALL asynchronously force:
- FSM to IDLE;
- FIFO count to 0;
- m_valid=0, m_last=0, m_data=0, m_chan=0;
- s_ready=0;
- rr_ptr=N_CH-1, so channel 0 wins first.
REQ-018 Reset asserted mid-packet SHALL discard the partial packet and all buffered beats. After deassertion, arbitration SHALL restart from IDLE.
REQ-019 Reset deassertion SHALL be synchronised to clk by the integrator; the block SHALL change no state on the deassertion edge itself.

Structure
REQ-020 Package axis_mux_pkg SHALL hold the FSM state typedef {IDLE, PKT} and the MODE constants MODE_FIXED=0 and MODE_RR=1.
REQ-021 The 2-entry output FIFO SHALL be a separate sub-module, axis_skid_fifo, parameterised by payload width.
REQ-022 The round-robin search SHALL be a combinational priority loop over N_CH channels inside axis_arb_mux.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- MODE=0, sel=2, 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd), m_ready=1 -> m_data A1,A2,A3 on consecutive cycles, m_last only on A3, m_chan=2.
- MODE=0, sel switched 2->0 after beat 1 of a 4-beat packet -> all 4 beats from channel 2 delivered; the next packet comes from channel 0.
- MODE=1, all 4 channels continuously valid with 1-beat packets -> m_chan sequence 0,1,2,3,0, with one idle cycle between beats.
- m_ready held low for 5 cycles during a packet -> exactly 2 beats buffered, s_ready[grant]=0, m_data stable, no beat lost or duplicated after release.
- Reset pulsed low mid-packet with 2 beats buffered -> m_valid=0 immediately (asynchronous); the next packet after release comes from channel 0 (MODE=1).
- MODE=0, sel=5 with N_CH=4 -> s_ready stays 0 and m_valid stays 0.
